// File: rtl/mips32_mem_responder.sv
// Single-ported word memory shared by the fetch and data ports, with fixed-latency tagged responses.
// Optional grant counters are enabled by defining MIPS32_MEM_STATS_EN.
module mips32_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              rsp_err
`ifdef MIPS32_MEM_STATS_EN
    ,
    output logic [15:0]       stat_if_grants,
    output logic [15:0]       stat_d_grants
`endif
);

    localparam int SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int LAST = LATENCY - 1;
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0]   STARVE_ONE = SW'(1);
    localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);

    logic [31:0]         mem_q [DEPTH];
    logic [31:0]         data_q [LATENCY];
    logic [SW-1:0]       starve_q, starve_d;
    logic [LATENCY-1:0]  vld_q, vld_d, tag_q, tag_d, err_q, err_d, st_q, st_d;
    logic                if_rsp_valid_q, if_rsp_valid_d, d_rsp_valid_q, d_rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         if_rsp_data_q, if_rsp_data_d, d_rsp_data_q, d_rsp_data_d;
    logic                gnt_if_s, gnt_d_s, gnt_s, in_range_s, wr_en_s, force_if_s;
    logic [ADDR_W-1:0]   gnt_addr_s;
    logic [31:0]         rdata_s;

    // Data port wins unless fetch has waited STARVE_MAX cycles; nothing is granted in reset.
    always_comb begin
        force_if_s = if_req_valid && (starve_q >= STARVE_LIM);
        gnt_d_s    = !rst && d_req_valid && !force_if_s;
        gnt_if_s   = !rst && if_req_valid && !gnt_d_s;
        gnt_s      = gnt_d_s || gnt_if_s;
        gnt_addr_s = gnt_d_s ? d_req_addr : if_req_addr;
        in_range_s = ({1'b0, gnt_addr_s} < DEPTH_L);
        wr_en_s    = gnt_d_s && d_req_we && in_range_s;
        if (if_req_valid && !gnt_if_s) begin
            starve_d = (starve_q >= STARVE_LIM) ? starve_q : starve_q + STARVE_ONE;
        end else begin
            starve_d = '0;
        end
    end

    assign if_req_ready = gnt_if_s;
    assign d_req_ready  = gnt_d_s;

    // Response control pipeline: stage 0 captures the grant, later stages shift.
    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        err_d    = err_q;
        st_d     = st_q;
        vld_d[0] = gnt_s;
        tag_d[0] = gnt_d_s;
        err_d[0] = gnt_s && !in_range_s;
        st_d[0]  = gnt_d_s && d_req_we;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
            err_d[i] = err_q[i-1];
            st_d[i]  = st_q[i-1];
        end
    end

    // Final stage decoded into per-port registered responses.
    always_comb begin
        rdata_s        = err_q[LAST] ? 32'hDEAD_BEEF : data_q[LAST];
        if_rsp_valid_d = vld_q[LAST] && !tag_q[LAST];
        d_rsp_valid_d  = vld_q[LAST] && tag_q[LAST];
        rsp_err_d      = vld_q[LAST] && err_q[LAST];
        if (if_rsp_valid_d) begin
            if_rsp_data_d = rdata_s;
        end else begin
            if_rsp_data_d = 32'h0000_0000;
        end
        if (d_rsp_valid_d) begin
            d_rsp_data_d = st_q[LAST] ? 32'h0000_0000 : rdata_s;
        end else begin
            d_rsp_data_d = 32'h0000_0000;
        end
    end

    // Storage and read-data shift chain; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[gnt_addr_s] <= d_req_wdata;
        end
        data_q[0] <= mem_q[gnt_addr_s];
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    // Control state and output registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q       <= '0;
            vld_q          <= '0;
            tag_q          <= '0;
            err_q          <= '0;
            st_q           <= '0;
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            rsp_err_q      <= 1'b0;
            if_rsp_data_q  <= 32'h0000_0000;
            d_rsp_data_q   <= 32'h0000_0000;
        end else begin
            starve_q       <= starve_d;
            vld_q          <= vld_d;
            tag_q          <= tag_d;
            err_q          <= err_d;
            st_q           <= st_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            if_rsp_data_q  <= if_rsp_data_d;
            d_rsp_data_q   <= d_rsp_data_d;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;
    assign rsp_err      = rsp_err_q;

`ifdef MIPS32_MEM_STATS_EN
    logic [15:0] stat_if_q, stat_if_d, stat_d_q, stat_d_d;

    // Saturating grant counters.
    always_comb begin
        if (gnt_if_s && (stat_if_q != 16'hFFFF)) begin
            stat_if_d = stat_if_q + 16'd1;
        end else begin
            stat_if_d = stat_if_q;
        end
        if (gnt_d_s && (stat_d_q != 16'hFFFF)) begin
            stat_d_d = stat_d_q + 16'd1;
        end else begin
            stat_d_d = stat_d_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_q <= 16'h0000;
            stat_d_q  <= 16'h0000;
        end else begin
            stat_if_q <= stat_if_d;
            stat_d_q  <= stat_d_d;
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_d_grants  = stat_d_q;
`endif

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed self-checking bench for mips32_mem_responder (DEPTH=1000, LATENCY=2, STARVE_MAX=3).
module tb_mips32_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [9:0]  if_req_addr;
    logic [31:0] if_rsp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, rsp_err;
    logic [9:0]  d_req_addr;
    logic [31:0] d_req_wdata, d_rsp_data;
`ifdef MIPS32_MEM_STATS_EN
    logic [15:0] stat_if_grants, stat_d_grants;
`endif

    mips32_mem_responder #(.ADDR_W(10), .DEPTH(1000), .LATENCY(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .rsp_err(rsp_err)
`ifdef MIPS32_MEM_STATS_EN
        , .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int both_ready = 0;
    int stray_err = 0;
    int          d_cyc_q[$];
    logic [31:0] d_dat_q[$];
    logic        d_err_q[$];
    int          i_cyc_q[$];
    logic [31:0] i_dat_q[$];
    logic        i_err_q[$];
    int          gnt_cyc_q[$];
    string       gnt_str;

    always @(posedge clk) cyc <= cyc + 1;

    // Response / grant recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (d_rsp_valid) begin
            d_cyc_q.push_back(cyc); d_dat_q.push_back(d_rsp_data); d_err_q.push_back(rsp_err);
        end
        if (if_rsp_valid) begin
            i_cyc_q.push_back(cyc); i_dat_q.push_back(if_rsp_data); i_err_q.push_back(rsp_err);
        end
        if (d_req_valid && d_req_ready) begin
            gnt_str = {gnt_str, "D"}; gnt_cyc_q.push_back(cyc);
        end
        if (if_req_valid && if_req_ready) begin
            gnt_str = {gnt_str, "I"}; gnt_cyc_q.push_back(cyc);
        end
        if (if_req_ready && d_req_ready) both_ready++;
        if (rsp_err && !d_rsp_valid && !if_rsp_valid) stray_err++;
    end

    task automatic clear_mon();
        d_cyc_q.delete(); d_dat_q.delete(); d_err_q.delete();
        i_cyc_q.delete(); i_dat_q.delete(); i_err_q.delete();
        gnt_cyc_q.delete(); gnt_str = "";
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic d_issue(input logic we, input logic [9:0] a, input logic [31:0] wd);
        int k;
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd;
        k = 0;
        @(negedge clk);
        while (!d_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (d_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL d_grant_timeout addr=%0d got ready=%b want 1", a, d_req_ready);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    task automatic f_issue(input logic [9:0] a);
        int k;
        if_req_valid = 1'b1; if_req_addr = a;
        k = 0;
        @(negedge clk);
        while (!if_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (if_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL if_grant_timeout addr=%0d got ready=%b want 1", a, if_req_ready);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        logic [68:0] obs;
        obs = {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, rsp_err, if_rsp_data, d_rsp_data};
        n_cmp++;
        if (obs !== 69'd0) begin
            n_fail++;
            $display("FAIL %s outputs got %h want 0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 10'd0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 10'd0; d_req_wdata = 32'd0;
        #12;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        check_outputs_zero("reset_state");
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_store_load();
        clear_mon();
        d_issue(1'b1, 10'd5, 32'h1234_5678);
        d_issue(1'b0, 10'd5, 32'h0);
        wait_cycles(6);
        n_cmp++;
        if (d_cyc_q.size() != 2) begin
            n_fail++;
            $display("FAIL sl_count got %0d want 2", d_cyc_q.size());
        end else begin
            n_cmp += 4;
            if (d_dat_q[0] !== 32'h0) begin
                n_fail++; $display("FAIL sl_ack_data got %h want 0", d_dat_q[0]);
            end
            if (d_dat_q[1] !== 32'h1234_5678) begin
                n_fail++; $display("FAIL sl_load_data got %h want 12345678", d_dat_q[1]);
            end
            if ({d_err_q[0], d_err_q[1]} !== 2'b00) begin
                n_fail++; $display("FAIL sl_err got %b%b want 00", d_err_q[0], d_err_q[1]);
            end
            if ((d_cyc_q[1] - d_cyc_q[0] != 1) || (d_cyc_q[0] - gnt_cyc_q[0] != 3)) begin
                n_fail++;
                $display("FAIL sl_timing got gap=%0d lat=%0d want gap=1 lat=3",
                         d_cyc_q[1] - d_cyc_q[0], d_cyc_q[0] - gnt_cyc_q[0]);
            end
        end
    endtask

    task automatic test_starvation();
        clear_mon();
        if_req_valid = 1'b1; if_req_addr = 10'd5;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'd5;
        repeat (8) @(posedge clk);
        #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        wait_cycles(6);
        n_cmp++;
        if (gnt_str != "DDDIDDDI") begin
            n_fail++; $display("FAIL starve_seq got %s want DDDIDDDI", gnt_str);
        end
        n_cmp++;
        if (i_cyc_q.size() != 2 || d_cyc_q.size() != 6) begin
            n_fail++;
            $display("FAIL starve_rsp_count got if=%0d d=%0d want if=2 d=6", i_cyc_q.size(), d_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) d_issue(1'b1, 10'(i), 32'h0000_0A00 + 32'(i));
        wait_cycles(4);
        clear_mon();
        for (int i = 0; i < 4; i++) f_issue(10'(i));
        wait_cycles(6);
        n_cmp++;
        if (i_cyc_q.size() != 4) begin
            n_fail++; $display("FAIL b2b_count got %0d want 4", i_cyc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (i_dat_q[i] !== 32'h0000_0A00 + 32'(i) || i_err_q[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d got %h err=%b want %h err=0", i, i_dat_q[i], i_err_q[i],
                             32'h0000_0A00 + 32'(i));
                end
            end
            n_cmp++;
            if (i_cyc_q[3] - i_cyc_q[0] != 3) begin
                n_fail++; $display("FAIL b2b_span got %0d want 3", i_cyc_q[3] - i_cyc_q[0]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp_dat [7];
        logic        exp_err [7];
        exp_dat = '{32'hDEAD_BEEF, 32'h0, 32'h0000_0999, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0996, 32'h0000_0020};
        exp_err = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        d_issue(1'b1, 10'd996, 32'h0000_0996);
        d_issue(1'b1, 10'd20,  32'h0000_0020);
        d_issue(1'b1, 10'd999, 32'h0000_0999);
        wait_cycles(4);
        clear_mon();
        stray_err = 0;
        d_issue(1'b0, 10'd1010, 32'h0);
        d_issue(1'b1, 10'd1020, 32'hFFFF_FFFF);
        d_issue(1'b0, 10'd999,  32'h0);
        d_issue(1'b0, 10'd1000, 32'h0);
        d_issue(1'b0, 10'd1020, 32'h0);
        d_issue(1'b0, 10'd996,  32'h0);
        d_issue(1'b0, 10'd20,   32'h0);
        f_issue(10'd1023);
        wait_cycles(6);
        n_cmp++;
        if (d_cyc_q.size() != 7) begin
            n_fail++; $display("FAIL oor_count got %0d want 7", d_cyc_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (d_dat_q[i] !== exp_dat[i] || d_err_q[i] !== exp_err[i]) begin
                    n_fail++;
                    $display("FAIL oor_rsp%0d got %h err=%b want %h err=%b", i, d_dat_q[i], d_err_q[i],
                             exp_dat[i], exp_err[i]);
                end
            end
        end
        n_cmp++;
        if (i_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL oor_fetch_count got %0d want 1", i_cyc_q.size());
        end else if (i_dat_q[0] !== 32'hDEAD_BEEF || i_err_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL oor_fetch got %h err=%b want deadbeef err=1", i_dat_q[0], i_err_q[0]);
        end
        n_cmp++;
        if (stray_err != 0) begin
            n_fail++; $display("FAIL oor_stray_err got %0d want 0", stray_err);
        end
    endtask

    task automatic test_reset_flush();
        clear_mon();
        d_issue(1'b0, 10'd5, 32'h0);
        d_issue(1'b0, 10'd6, 32'h0);
        rst = 1'b1;
        d_req_valid = 1'b1;
        #1;
        check_outputs_zero("reset_mid_op");
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        rst = 1'b0;
        wait_cycles(8);
        n_cmp++;
        if (d_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL flush_rsp_count got %0d want 0", d_cyc_q.size());
        end
        clear_mon();
        d_issue(1'b0, 10'd5, 32'h0);
        wait_cycles(5);
        n_cmp++;
        if (d_dat_q.size() != 1 || d_dat_q[0] !== 32'h1234_5678) begin
            n_fail++; $display("FAIL flush_mem_kept got n=%0d want 1 rsp of 12345678", d_dat_q.size());
        end
    endtask

`ifdef MIPS32_MEM_STATS_EN
    task automatic test_stats();
        logic [15:0] if_before;
        if_before = stat_if_grants;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'd1;
        repeat (70000) @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        wait_cycles(2);
        n_cmp++;
        if (stat_d_grants !== 16'hFFFF || stat_if_grants !== if_before) begin
            n_fail++;
            $display("FAIL stats got d=%h if=%h want d=ffff if=%h", stat_d_grants, stat_if_grants, if_before);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_store_load();
        test_starvation();
        test_back_to_back();
        test_out_of_range();
        test_reset_flush();
`ifdef MIPS32_MEM_STATS_EN
        test_stats();
`endif
        n_cmp++;
        if (both_ready != 0) begin
            n_fail++; $display("FAIL dual_ready got %0d cycles want 0", both_ready);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
